// File: rtl/pwm_wavegen.sv
// -----------------------------------------------------------------------------
// pwm_wavegen
//
// Purpose
//   Multi-channel, clock-synchronous PWM / waveform generator. Each channel
//   runs a free counter over a programmable period and drives its output high
//   for the first `ton` cycles of every period. A new configuration is first
//   written into a per-channel shadow register. It is copied into the active
//   register only at the channel's period boundary, or at once when the
//   channel is idle, so a running waveform is never cut short or glitched.
//
// Parameters
//   NUM_CH  number of independent channels (>= 1)
//   CNT_W   width of the period, on-time and counter fields
//   CH_W    channel-select width, derived from NUM_CH (minimum 1)
//
// Ports
//   clk           in   1       system clock; all state changes on posedge
//   rst           in   1       synchronous, active-high reset
//   cfg_valid     in   1       configuration request
//   cfg_ready     out  1       request accepted when cfg_valid && cfg_ready
//   cfg_ch        in   CH_W    target channel
//   cfg_period    in   CNT_W   period in cycles (0 disables the channel)
//   cfg_ton       in   CNT_W   on-time in cycles
//   cfg_en        in   1       channel enable
//   pwm_out       out  NUM_CH  per-channel waveform
//   period_start  out  NUM_CH  one-cycle pulse in the first cycle of a period
// -----------------------------------------------------------------------------
module pwm_wavegen #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_ton,
    input  logic              cfg_en,
    output logic [NUM_CH-1:0] pwm_out,
    output logic [NUM_CH-1:0] period_start
);

    // One channel configuration: the same layout is used for the shadow
    // copy (written by the config port) and the active copy (decoded).
    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] ton;
        logic             en;
    } ch_cfg_t;

    // Per-channel status collected from the channel slices below.
    logic [NUM_CH-1:0] pend_vec;
    logic [NUM_CH-1:0] wr_sel;
    logic              accept;

    // Config handshake: a transfer happens on a rising edge where both
    // cfg_valid and cfg_ready are high. cfg_ready is low only while the
    // addressed channel still holds an unapplied shadow value; it is a pure
    // function of cfg_ch and the pend flags, never of cfg_valid, so a
    // requester may wait on it freely. A channel number outside the
    // implemented range is always ready and its write is silently dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = !pend_vec[i];
            end
        end
    end

    assign accept = cfg_valid && cfg_ready;

    // Write strobe per channel; an out-of-range cfg_ch matches no channel.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_sel[i] = accept && (cfg_ch == CH_W'(i));
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch

        ch_cfg_t          act;
        ch_cfg_t          shd;
        logic             pend;
        logic [CNT_W-1:0] cnt;

        logic             running;
        logic             at_end;
        logic             apply;

        // A channel with period 0 or enable low is idle: its counter rests
        // at 0 and its outputs are low.
        assign running = act.en && (act.period != '0);

        // Last cycle of the current period. For period 1 this is true every
        // cycle, so the counter stays at 0 and period_start stays high.
        assign at_end = (cnt == (act.period - CNT_W'(1)));

        // The shadow value moves to the active copy at the period boundary,
        // or on the very next edge when the channel is idle. pend must
        // already be set before the edge, so a write accepted on a boundary
        // edge waits for the following boundary.
        assign apply = pend && (!running || at_end);

        always_ff @(posedge clk) begin
            if (rst) begin
                act  <= '0;
                shd  <= '0;
                pend <= 1'b0;
                cnt  <= '0;
            end else begin
                // wr_sel requires pend == 0 and apply requires pend == 1,
                // so the two branches below never fire on the same edge.
                if (wr_sel[i]) begin
                    shd.period <= cfg_period;
                    shd.ton    <= cfg_ton;
                    shd.en     <= cfg_en;
                    pend       <= 1'b1;
                end

                if (apply) begin
                    act  <= shd;
                    cnt  <= '0;
                    pend <= 1'b0;
                end else if (running) begin
                    cnt <= at_end ? '0 : cnt + CNT_W'(1);
                end else begin
                    cnt <= '0;
                end
            end
        end

        assign pend_vec[i] = pend;

        // Outputs decode flops only. The unsigned compare makes ton >= period
        // a constant-high waveform and ton == 0 a constant-low one.
        assign pwm_out[i]      = running && (cnt < act.ton);
        assign period_start[i] = running && (cnt == '0);

        // Structural invariants of the channel slice.
        a_wr_apply_excl : assert property (@(posedge clk) disable iff (rst)
            !(wr_sel[i] && apply));
        a_cnt_in_range : assert property (@(posedge clk) disable iff (rst)
            running |-> (cnt < act.period));

    end : g_ch

endmodule
